// File: rtl/fetch_align_buffer_pkg.sv
// Shared types and helpers for the RV32IC fetch realigner and its optional
// compressed-instruction expander (enabled with RVC_EXPAND_EN).
package fetch_align_buffer_pkg;

  localparam logic [31:0] FA_RESET_PC      = 32'h0000_0060;
  localparam logic [31:0] FA_ILLEGAL_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    fa_idle  = 2'd0,
    fa_req   = 2'd1,
    fa_drain = 2'd2
  } fa_state_e;

  // Quadrant field of a halfword; 2'b11 marks a full 32-bit instruction.
  typedef enum logic [1:0] {
    RVC_Q0    = 2'b00,
    RVC_Q1    = 2'b01,
    RVC_Q2    = 2'b10,
    RVC_NOT_C = 2'b11
  } rv32ic_opcode_e;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } rv32i_opcode_e;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  // Branch/jump offsets are passed without their always-zero bit 0.
  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/fetch_align_buffer_rvc_expand.sv
// Combinational RV32C -> RV32I expander; unsupported FP and reserved
// encodings map to the all-ones illegal pattern.
module rvc_expand
  import fetch_align_buffer_pkg::*;
(
  input  logic [15:0] c_instr_i,
  output logic [31:0] instr_o
);

  logic [15:0] c;
  logic [4:0]  rd, rs2, rs1p, rdp;
  logic [11:0] imm6;
  logic [9:0]  addi4spn_imm;
  logic [6:0]  lw_imm;
  logic [7:0]  lwsp_imm, swsp_imm;
  logic [11:0] addi16sp_imm;
  logic [20:1] j_imm;
  logic [12:1] b_imm;

  assign c            = c_instr_i;
  assign rd           = c[11:7];
  assign rs2          = c[6:2];
  assign rs1p         = {2'b01, c[9:7]};
  assign rdp          = {2'b01, c[4:2]};
  assign imm6         = {{6{c[12]}}, c[12], c[6:2]};
  assign addi4spn_imm = {c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign lw_imm       = {c[5], c[12:10], c[6], 2'b00};
  assign lwsp_imm     = {c[3:2], c[12], c[6:4], 2'b00};
  assign swsp_imm     = {c[8:7], c[12:9], 2'b00};
  assign addi16sp_imm = {{2{c[12]}}, c[12], c[4], c[3], c[5], c[2], c[6], 4'b0000};
  assign j_imm        = {{9{c[12]}}, c[12], c[8], c[10], c[9], c[6], c[7], c[2], c[11], c[5], c[4], c[3]};
  assign b_imm        = {{4{c[12]}}, c[12], c[6], c[5], c[2], c[11], c[10], c[4], c[3]};

  always_comb begin
    instr_o = FA_ILLEGAL_INSTR;
    case (rv32ic_opcode_e'(c[1:0]))
      RVC_Q0: begin
        case (c[15:13])
          3'b000: if (addi4spn_imm != 10'd0)
                    instr_o = enc_i({2'b00, addi4spn_imm}, 5'd2, 3'b000, rdp, OPC_OP_IMM);
          3'b010: instr_o = enc_i({5'd0, lw_imm}, rs1p, 3'b010, rdp, OPC_LOAD);
          3'b110: instr_o = enc_s({5'd0, lw_imm}, rdp, rs1p, 3'b010, OPC_STORE);
          default: ;
        endcase
      end
      RVC_Q1: begin
        case (c[15:13])
          3'b000: instr_o = enc_i(imm6, rd, 3'b000, rd, OPC_OP_IMM);
          3'b001: instr_o = enc_j(j_imm, 5'd1);
          3'b010: instr_o = enc_i(imm6, 5'd0, 3'b000, rd, OPC_OP_IMM);
          3'b011: begin
            if (rd == 5'd2) begin
              if (addi16sp_imm != 12'd0)
                instr_o = enc_i(addi16sp_imm, 5'd2, 3'b000, 5'd2, OPC_OP_IMM);
            end else if ({c[12], c[6:2]} != 6'd0) begin
              instr_o = {{14{c[12]}}, c[12], c[6:2], rd, OPC_LUI};
            end
          end
          3'b100: begin
            case (c[11:10])
              2'b00: instr_o = enc_i({7'b0000000, c[6:2]}, rs1p, 3'b101, rs1p, OPC_OP_IMM);
              2'b01: instr_o = enc_i({7'b0100000, c[6:2]}, rs1p, 3'b101, rs1p, OPC_OP_IMM);
              2'b10: instr_o = enc_i(imm6, rs1p, 3'b111, rs1p, OPC_OP_IMM);
              default: begin
                if (!c[12]) begin
                  case (c[6:5])
                    2'b00:   instr_o = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p, OPC_OP);
                    2'b01:   instr_o = enc_r(7'b0000000, rdp, rs1p, 3'b100, rs1p, OPC_OP);
                    2'b10:   instr_o = enc_r(7'b0000000, rdp, rs1p, 3'b110, rs1p, OPC_OP);
                    default: instr_o = enc_r(7'b0000000, rdp, rs1p, 3'b111, rs1p, OPC_OP);
                  endcase
                end
              end
            endcase
          end
          3'b101: instr_o = enc_j(j_imm, 5'd0);
          3'b110: instr_o = enc_b(b_imm, 5'd0, rs1p, 3'b000);
          default: instr_o = enc_b(b_imm, 5'd0, rs1p, 3'b001);
        endcase
      end
      RVC_Q2: begin
        case (c[15:13])
          3'b000: instr_o = enc_i({7'd0, c[6:2]}, rd, 3'b001, rd, OPC_OP_IMM);
          3'b010: instr_o = enc_i({4'd0, lwsp_imm}, 5'd2, 3'b010, rd, OPC_LOAD);
          3'b110: instr_o = enc_s({4'd0, swsp_imm}, rs2, 5'd2, 3'b010, OPC_STORE);
          3'b100: begin
            if (!c[12]) begin
              if (rs2 != 5'd0)     instr_o = enc_r(7'd0, rs2, 5'd0, 3'b000, rd, OPC_OP);
              else if (rd != 5'd0) instr_o = enc_i(12'd0, rd, 3'b000, 5'd0, OPC_JALR);
            end else begin
              if (rs2 != 5'd0)     instr_o = enc_r(7'd0, rs2, rd, 3'b000, rd, OPC_OP);
              else if (rd != 5'd0) instr_o = enc_i(12'd0, rd, 3'b000, 5'd1, OPC_JALR);
              else                 instr_o = 32'h0010_0073;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_align_buffer.sv
// RV32IC fetch realigner: word fetches feed a halfword queue that presents one
// aligned instruction per handshake. RVC_EXPAND_EN expands 16-bit instructions.
module fetch_align_buffer
  import fetch_align_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FA_RESET_PC,
  parameter int          HQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_is_c
);

  localparam int PW = $clog2(HQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(HQ_DEPTH);

  logic [15:0]   hq_q [HQ_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   head_pc_q, head_pc_d, fetch_pc_q, fetch_pc_d, drain_addr_q, drain_addr_d;
  fa_state_e     state_q, state_d;

  logic [15:0]   head_hw, next_hw;
  logic          head_is_32, pop;
  logic [CW-1:0] need, count_after, free_now, free_after;
  logic [1:0]    push_n;
  logic [31:0]   redirect_even, fetch_word, c_instr;

  assign head_hw       = hq_q[rd_ptr_q];
  assign next_hw       = hq_q[rd_ptr_q + PW'(1)];
  assign head_is_32    = (head_hw[1:0] == 2'b11);
  assign need          = head_is_32 ? CW'(2) : CW'(1);
  assign instr_valid   = (count_q >= need);
  assign pop           = instr_valid && instr_ready && !flush;
  assign redirect_even = redirect_pc & 32'hFFFF_FFFE;
  assign fetch_word    = fetch_pc_q & 32'hFFFF_FFFC;

  // After a redirect to an odd halfword only the upper half of the first word is live.
  always_comb begin
    push_n = 2'd0;
    if (state_q == fa_req && imem_resp && !flush)
      push_n = fetch_pc_q[1] ? 2'd1 : 2'd2;
  end

  assign count_after = count_q - (pop ? need : CW'(0)) + CW'(push_n);
  assign free_now    = DEPTH_C - count_q;
  assign free_after  = DEPTH_C - count_after;

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;

    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      head_pc_d  = redirect_even;
      fetch_pc_d = redirect_even;
    end else begin
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PW'(need);
        head_pc_d = head_pc_q + (head_is_32 ? 32'd4 : 32'd2);
      end
      if (push_n != 2'd0) begin
        wr_ptr_d   = wr_ptr_q + PW'(push_n);
        fetch_pc_d = fetch_word + 32'd4;
      end
      count_d = count_after;
    end

    case (state_q)
      fa_idle: if (!flush && free_now >= CW'(2)) state_d = fa_req;
      fa_req: begin
        if (flush) begin
          // A response landing with the flush already closed the bus transaction.
          state_d      = imem_resp ? fa_idle : fa_drain;
          drain_addr_d = fetch_word;
        end else if (imem_resp) begin
          state_d = (free_after >= CW'(2)) ? fa_req : fa_idle;
        end
      end
      fa_drain: if (imem_resp) state_d = fa_req;
      default: state_d = fa_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= fa_idle;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_pc_q    <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // Queue storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0)
      hq_q[wr_ptr_q] <= (push_n == 2'd2) ? imem_rdata[15:0] : imem_rdata[31:16];
    if (push_n == 2'd2)
      hq_q[wr_ptr_q + PW'(1)] <= imem_rdata[31:16];
  end

  assign imem_read = (state_q != fa_idle);
  assign imem_addr = (state_q == fa_drain) ? drain_addr_q : fetch_word;

`ifdef RVC_EXPAND_EN
  rvc_expand u_rvc_expand (
    .c_instr_i (head_hw),
    .instr_o   (c_instr)
  );
`else
  assign c_instr = {16'h0000, head_hw};
`endif

  assign instr      = !instr_valid ? 32'd0 : (head_is_32 ? {next_hw, head_hw} : c_instr);
  assign instr_pc   = head_pc_q;
  assign instr_is_c = instr_valid && !head_is_32;

endmodule
